// File: rtl/uart_word_pkg.sv
// Shared definitions for the UART word transmitter.
//   - FSM state encodings (IDLE, START, DATA, STOP)
//   - TX_IDLE_LEVEL: UART line level when no frame is in flight
//   - byte_cnt_w(): width of a counter that indexes n_frames frames
package uart_word_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // A single-frame word still needs a 1-bit counter.
  function automatic int unsigned byte_cnt_w(input int unsigned n_frames);
    return (n_frames > 1) ? $clog2(n_frames) : 1;
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO, first-word-fall-through read port.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push, din      write request and data (ignored when full)
//   pop            read request (ignored when empty), dout shows the head word
//   full, empty    occupancy flags derived from level
//   level          current occupancy, 0..DEPTH
module uart_word_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // A full FIFO never accepts, even if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_word_tx.sv
// UART word transmitter: buffers WORD_W-bit words and sends each one as
// WORD_W/8 back-to-back 8N1 frames on tx.
// Optional feature: define UART_WORD_TX_CHECKSUM_EN to append one frame
// carrying the XOR of all bytes of the word.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   tx_en        word valid; tx_reg sampled when tx_en && tx_ready
//   tx_ready     FIFO not full (combinational)
//   tx_busy      FSM active or FIFO non-empty (combinational)
//   overflow     sticky: tx_en seen while tx_ready was low
//   fifo_level   FIFO occupancy
//   tx           registered UART line, idle high
module uart_word_tx
  import uart_word_pkg::*;
#(
  parameter int unsigned WORD_W         = 64,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CLKS_PER_BIT   = 87,
  parameter bit          MSB_BYTE_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en,
  input  logic [WORD_W-1:0]             tx_reg,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx
);

  localparam int unsigned N_BYTES = WORD_W / 8;
`ifdef UART_WORD_TX_CHECKSUM_EN
  localparam int unsigned N_FRAMES = N_BYTES + 1;
`else
  localparam int unsigned N_FRAMES = N_BYTES;
`endif
  localparam int unsigned BCW = byte_cnt_w(N_FRAMES);
  localparam int unsigned TW  = $clog2(CLKS_PER_BIT);

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        bit_q, bit_d;
  logic [BCW-1:0]    byte_q, byte_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              tx_d;

  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_c;
  logic              pop_c;
  logic              timer_done_c;
  logic              last_frame_c;
  logic [7:0]        cur_byte_c;

`ifdef UART_WORD_TX_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic [7:0] word_xor_c;

  // XOR of every byte of the head word, captured at pop time.
  always_comb begin
    word_xor_c = '0;
    for (int i = 0; i < int'(N_BYTES); i++) begin
      word_xor_c = word_xor_c ^ fifo_dout[i*8 +: 8];
    end
  end
`endif

  assign push_c     = tx_en && tx_ready;
  assign tx_ready   = !fifo_full;
  assign tx_busy    = (state_q != ST_IDLE) || !fifo_empty;

  uart_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (tx_reg),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign timer_done_c = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign last_frame_c = (byte_q == BCW'(N_FRAMES - 1));

  // Current byte: the shift register always presents the next byte at one end.
  always_comb begin
    cur_byte_c = MSB_BYTE_FIRST ? shreg_q[WORD_W-1 -: 8] : shreg_q[7:0];
`ifdef UART_WORD_TX_CHECKSUM_EN
    if (byte_q == BCW'(N_BYTES)) cur_byte_c = csum_q;
`endif
  end

  // Next-state and datapath logic; tx_d is the line level for this state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_done_c ? '0 : timer_q + TW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    pop_c   = 1'b0;
    tx_d    = TX_IDLE_LEVEL;
`ifdef UART_WORD_TX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shreg_d = fifo_dout;
          byte_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
`ifdef UART_WORD_TX_CHECKSUM_EN
          csum_d  = word_xor_c;
`endif
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (timer_done_c) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = cur_byte_c[bit_q];
        if (timer_done_c) begin
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_STOP: begin
        tx_d = TX_IDLE_LEVEL;
        if (timer_done_c) begin
          if (last_frame_c) begin
            state_d = ST_IDLE;
          end else begin
            byte_d  = byte_q + BCW'(1);
            shreg_d = MSB_BYTE_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
            state_d = ST_START;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shreg_q  <= '0;
      tx       <= TX_IDLE_LEVEL;
      overflow <= 1'b0;
`ifdef UART_WORD_TX_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shreg_q  <= shreg_d;
      tx       <= tx_d;
      overflow <= overflow | (tx_en & ~tx_ready);
`ifdef UART_WORD_TX_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: two instances (MSB-first and LSB-first byte order)
// share stimulus; a UART receiver per instance checks frames against a
// queue of expected bytes filled as words are driven.
module tb_uart_word_tx;

  localparam int unsigned W     = 64;
  localparam int unsigned D     = 4;
  localparam int unsigned C     = 4;
  localparam int unsigned NB    = W / 8;
  localparam int unsigned LW    = $clog2(D) + 1;
  localparam int          FRAME = 10 * C;

  typedef struct {
    logic [7:0] b;
    int         gap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_en = 1'b0;
  logic [W-1:0]  tx_reg = '0;

  logic          ready_m, busy_m, ovf_m, tx_m;
  logic          ready_l, busy_l, ovf_l, tx_l;
  logic [LW-1:0] lvl_m, lvl_l;
  logic [1:0]    txv;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   prev_start [2];
  exp_t q0 [$];
  exp_t q1 [$];

  assign txv = {tx_l, tx_m};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_word_tx #(
    .WORD_W(W), .FIFO_DEPTH(D), .CLKS_PER_BIT(C), .MSB_BYTE_FIRST(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_reg(tx_reg),
    .tx_ready(ready_m), .tx_busy(busy_m), .overflow(ovf_m),
    .fifo_level(lvl_m), .tx(tx_m)
  );

  uart_word_tx #(
    .WORD_W(W), .FIFO_DEPTH(D), .CLKS_PER_BIT(C), .MSB_BYTE_FIRST(1'b0)
  ) dut_lsb (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_reg(tx_reg),
    .tx_ready(ready_l), .tx_busy(busy_l), .overflow(ovf_l),
    .fifo_level(lvl_l), .tx(tx_l)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Queue the frames a word must produce on each instance.
  task automatic expect_word(input logic [W-1:0] w, input int gap_first);
    exp_t e;
    for (int i = 0; i < int'(NB); i++) begin
      e.gap = (i == 0) ? gap_first : FRAME;
      e.b   = w[(int'(NB) - 1 - i)*8 +: 8];
      q0.push_back(e);
      e.b   = w[i*8 +: 8];
      q1.push_back(e);
    end
`ifdef UART_WORD_TX_CHECKSUM_EN
    e.b   = '0;
    e.gap = FRAME;
    for (int i = 0; i < int'(NB); i++) e.b = e.b ^ w[i*8 +: 8];
    q0.push_back(e);
    q1.push_back(e);
`endif
  endtask

  // UART receiver for instance id; frames cut short by rst are discarded.
  task automatic monitor(input int id);
    logic [7:0] b;
    logic       start_b, stop_b, aborted, pending;
    int         sc;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || txv[id] !== 1'b0) continue;
      sc = cyc; aborted = 1'b0; b = '0; start_b = 1'b1; stop_b = 1'b0;
      for (int j = 1; j <= int'(9*C + C/2); j++) begin
        @(negedge clk);
        if (rst !== 1'b0) begin aborted = 1'b1; break; end
        if (j == int'(C/2)) start_b = txv[id];
        else if (j >= int'(C) && j < int'(9*C) && (j % int'(C)) == int'(C/2))
          b[(j / int'(C)) - 1] = txv[id];
        else if (j == int'(9*C + C/2)) stop_b = txv[id];
      end
      if (aborted) continue;
      pending = (id == 0) ? (q0.size() != 0) : (q1.size() != 0);
      check($sformatf("frame_expected[%0d]@%0d", id, sc), pending, 1'b1);
      if (!pending) continue;
      e = (id == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("byte[%0d]@%0d", id, sc), b, e.b);
      check($sformatf("start_bit[%0d]@%0d", id, sc), start_b, 1'b0);
      check($sformatf("stop_bit[%0d]@%0d", id, sc), stop_b, 1'b1);
      if (e.gap != 0) check($sformatf("frame_gap[%0d]@%0d", id, sc), sc - prev_start[id], e.gap);
      prev_start[id] = sc;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy_m !== 1'b0 || busy_l !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < budget, 1'b1);
  endtask

  task automatic check_idle(input string tag, input logic ovf_exp);
    check({tag, "_tx"}, tx_m, 1'b1);
    check({tag, "_tx_lsb"}, tx_l, 1'b1);
    check({tag, "_ready"}, ready_m, 1'b1);
    check({tag, "_busy"}, busy_m, 1'b0);
    check({tag, "_overflow"}, ovf_m, ovf_exp);
    check({tag, "_level"}, lvl_m, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset values during and after reset.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("in_reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset", 1'b0);

    // Single word: byte order and first-start-bit latency.
    tx_reg = 64'h0123456789ABCDEF; tx_en = 1'b1;
    expect_word(tx_reg, 0);
    @(negedge clk); tx_en = 1'b0;
    check("e0_level", lvl_m, 1);
    check("e0_busy", busy_m, 1'b1);
    check("e0_tx", tx_m, 1'b1);
    @(negedge clk);
    check("e1_level", lvl_m, 0);
    check("e1_tx", tx_m, 1'b1);
    @(negedge clk);
    check("e2_start_msb", tx_m, 1'b0);
    check("e2_start_lsb", tx_l, 1'b0);
    wait_drain("drain_single", 1000);

    // Back-to-back words: one idle clock between words.
    tx_reg = 64'hDEADBEEFCAFEF00D; tx_en = 1'b1;
    expect_word(tx_reg, 0);
    @(negedge clk);
    tx_reg = 64'h00000000000000FF;
    expect_word(tx_reg, FRAME + 1);
    @(negedge clk); tx_en = 1'b0;
    wait_drain("drain_b2b", 2000);

    // Overflow: six pushes on consecutive edges, the sixth is dropped.
    for (int k = 1; k <= 6; k++) begin
      tx_reg = {8'(k), 56'h00C0FFEE123456}; tx_en = 1'b1;
      if (k <= 5) expect_word(tx_reg, (k == 1) ? 0 : FRAME + 1);
      @(negedge clk);
      if (k == 4) begin
        check("ovf_e3_ready", ready_m, 1'b1);
        check("ovf_e3_level", lvl_m, 3);
      end
      if (k == 5) begin
        check("ovf_e4_ready", ready_m, 1'b0);
        check("ovf_e4_level", lvl_m, 4);
        check("ovf_e4_overflow", ovf_m, 1'b0);
      end
      if (k == 6) begin
        check("ovf_e5_overflow", ovf_m, 1'b1);
        check("ovf_e5_overflow_lsb", ovf_l, 1'b1);
        check("ovf_e5_level", lvl_m, 4);
      end
    end
    tx_en = 1'b0;
    wait_drain("drain_overflow", 5000);
    check_idle("after_overflow", 1'b1);

    // Reset during the DATA state of the third byte, with a word queued.
    tx_reg = 64'h0123456789ABCDEF; tx_en = 1'b1;
    expect_word(tx_reg, 0);
    @(negedge clk);
    tx_reg = 64'hDEADBEEFCAFEF00D;
    expect_word(tx_reg, FRAME + 1);
    @(negedge clk); tx_en = 1'b0;
    repeat (2*FRAME + 12) @(negedge clk);
    check("pre_reset_level", lvl_m, 1);
    check("pre_reset_busy", busy_m, 1'b1);
    rst = 1'b1;
    #1;
    check_idle("mid_frame_reset", 1'b0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Clean transmission after reset.
    w = 64'h8000000000000001;
    tx_reg = w; tx_en = 1'b1;
    expect_word(w, 0);
    @(negedge clk); tx_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_reset_start", tx_m, 1'b0);
    wait_drain("drain_post_reset", 1000);
    check_idle("final", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
